// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 Hz pixel-timing path.
// Defaults here feed the vga_timing_gen parameters; totals are derived.
package vga_pkg;

    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_SYNC_DELAY = 2;

    localparam int DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of timing outputs from the generator to renderers and game logic.
// master: DrawX/DrawY, blank, hs/vs, line/frame/vblank strobes, frame_count.
interface vga_timing_gen_if;
    import vga_pkg::*;

    coord_t     DrawX;
    coord_t     DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic       vblank_tick;
    logic [7:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs,
        output line_start, frame_start, vblank_tick, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs,
        input line_start, frame_start, vblank_tick, frame_count
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// 2-bit shift register that delays {hs, vs}; all stages reset to 1.
// Ports: clk, rst (async, active-high), d (raw sync), q (delayed sync).
module sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] d,
    output logic [1:0] q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_delay
        logic [DEPTH-1:0][1:0] stage_q;
        logic [DEPTH-1:0][1:0] stage_d;

        always_comb begin
            stage_d    = stage_q;
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= '1;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: counters, blank, strobes, frame count, delayed sync.
// Ports: vga_clk, reset (async, active-high), vga (timing bundle, master).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic               vga_clk,
    input  logic               reset,
    vga_timing_gen_if.master   vga
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    coord_t     hc_q, hc_d;
    coord_t     vc_q, vc_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       blank_q, blank_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_tick_q, vblank_tick_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;
    logic [1:0] sync_dly;

    // Flags are decoded from the next count so they register on the
    // same edge as DrawX/DrawY and stay aligned with them.
    always_comb begin
        hc_d          = hc_q + coord_t'(1);
        vc_d          = vc_q;
        frame_count_d = frame_count_q;
        if (hc_q == coord_t'(H_TOTAL - 1)) begin
            hc_d = '0;
            vc_d = vc_q + coord_t'(1);
            if (vc_q == coord_t'(V_TOTAL - 1)) begin
                vc_d          = '0;
                frame_count_d = frame_count_q + 8'd1;
            end
        end

        blank_d       = (hc_d < coord_t'(H_VISIBLE))
                     && (vc_d < coord_t'(V_VISIBLE));
        line_start_d  = (hc_d == '0);
        frame_start_d = line_start_d && (vc_d == '0);
        vblank_tick_d = line_start_d
                     && (vc_d == coord_t'(V_VISIBLE));
        hs_raw_d      = !((hc_d >= coord_t'(HS_START))
                     && (hc_d < coord_t'(HS_END)));
        vs_raw_d      = !((vc_d >= coord_t'(VS_START))
                     && (vc_d < coord_t'(VS_END)));
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            frame_count_q <= '0;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_tick_q <= 1'b0;
            hs_raw_q      <= 1'b1;
            vs_raw_q      <= 1'b1;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_count_q <= frame_count_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_tick_q <= vblank_tick_d;
            hs_raw_q      <= hs_raw_d;
            vs_raw_q      <= vs_raw_d;
        end
    end

    // Extra delay matches the renderers' colour pipeline latency.
    sync_delay #(
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk (vga_clk),
        .rst (reset),
        .d   ({hs_raw_q, vs_raw_q}),
        .q   (sync_dly)
    );

    assign vga.DrawX       = hc_q;
    assign vga.DrawY       = vc_q;
    assign vga.blank       = blank_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.vblank_tick = vblank_tick_q;
    assign vga.frame_count = frame_count_q;
    assign vga.hs          = sync_dly[1];
    assign vga.vs          = sync_dly[0];

endmodule
